alarm_clock_ctrl_fsm: RTL
=========================

Name: alarm_clock_ctrl_fsm

Overview:
Parametrised control FSM for the alarm clock datapath. It sequences keypad digit entry into the shift register, with a configurable digit count, release detection, and an inactivity timeout. It commits entered digits to the alarm register or the current-time counter, and selects the display source. It sits between the keypad decoder/one-second divider and the clock datapath (key shift register, alarm register, time counter, display mux).

Parameters:
NUM_DIGITS, 4, number of BCD digits in one complete entry (>=1)
KEY_TIMEOUT, 10, one_second pulses without a new digit before entry is aborted (>=1)
NOKEY, 10, key code meaning "no key pressed"
REQUIRE_FULL, 1, 1: commit only when digit_count==NUM_DIGITS; 0: commit with any count >=1

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
key  input  4  keypad code; 0-9 digit, NOKEY none, other codes invalid
alarm_button  input  1  level, request alarm display / commit to alarm
time_button  input  1  level, commit entry to current time
one_second  input  1  one-cycle pulse per second
load_new_a  output  1  one-cycle pulse, load shift register into alarm register
show_a  output  1  display alarm time
show_new_time  output  1  display key-entry shift register
load_new_c  output  1  one-cycle pulse, load shift register into time counter
shift  output  1  one-cycle pulse, shift current key digit into shift register
digit_count  output  $clog2(NUM_DIGITS+1)  digits entered in current entry
entry_abort  output  1  one-cycle pulse, entry discarded by timeout

Behaviour:
- Reset is synchronous, active-high. On the next edge: state SHOW_TIME, digit_count 0, timer 0, all outputs 0. Reset mid-entry discards the entry with no load pulse.
- Outputs are Moore-decoded from the registered state. Exception: entry_abort is a registered pulse.
- Digit means key<=9. Release means key==NOKEY. Invalid codes (11-15) are neither digit nor release.
- SHOW_TIME, all outputs 0:
  - digit -> KEY_STORED
  - else alarm_button -> SHOW_ALARM
  - else stay; time_button is ignored.
- SHOW_ALARM, show_a=1: stay while alarm_button=1, else -> SHOW_TIME. Digits are ignored.
- KEY_STORED, shift=1, exactly one cycle:
  - digit_count += 1; timer cleared
  - -> KEY_WAITED unconditionally
- KEY_WAITED, show_new_time=1: release -> KEY_ENTRY. A held digit stays here, so one press produces one shift.
- KEY_ENTRY, show_new_time=1, priority order:
  1. digit and digit_count<NUM_DIGITS -> KEY_STORED. A digit when full is ignored and does not clear the timer.
  2. alarm_button and commit allowed -> SET_ALARM
  3. time_button and commit allowed -> SET_TIME
  4. Otherwise stay. Buttons are ignored when commit is not allowed.
- Commit allowed: REQUIRE_FULL ? digit_count==NUM_DIGITS : digit_count>=1.
- SET_ALARM: load_new_a=1 for one cycle -> SHOW_TIME, digit_count 0.
- SET_TIME: load_new_c=1 for one cycle -> SHOW_TIME, digit_count 0.
- Timeout timer:
  - counts one_second pulses in KEY_WAITED and KEY_ENTRY; one_second is ignored in other states
  - on the pulse that makes timer==KEY_TIMEOUT -> SHOW_TIME, digit_count 0, entry_abort=1 in the following cycle
  - the timeout takes priority over buttons in that cycle
  - a digit accepted in the same cycle as one_second wins and clears the timer
  - timer width $clog2(KEY_TIMEOUT+1); saturates, never wraps.
- digit_count never exceeds NUM_DIGITS and never wraps.
- At most one of load_new_a, load_new_c, shift is high in any cycle.
- show_a and show_new_time are never both high.

Test Plan:
- Reset asserted 2 cycles, then idle key=NOKEY for 20 cycles -> all outputs 0, digit_count 0.
- Defaults: keys 1,2,3,4, each held 3 cycles then NOKEY 2 cycles, then time_button 1 cycle:
  - exactly 4 shift pulses; digit_count reaches 4
  - show_new_time high from the first KEY_WAITED
  - a single load_new_c pulse, then SHOW_TIME with digit_count 0 and no load_new_a.
- Key 5 held 20 cycles -> exactly one shift. A 5th digit after 4 entered -> no shift, digit_count stays 4.
- REQUIRE_FULL=1:
  - 2 digits then alarm_button -> no load, remains in KEY_ENTRY
  - with 4 digits, alarm_button and time_button together -> load_new_a only.
  - REQUIRE_FULL=0, 1 digit then time_button -> load_new_c.
- Timeout:
  - 1 digit, then 10 one_second pulses -> entry_abort one cycle after the 10th pulse, SHOW_TIME, digit_count 0, no load
  - 9 pulses, then a digit -> timer cleared; 9 more pulses -> no abort.
- alarm_button held 5 cycles in SHOW_TIME -> show_a high exactly while held.
- Reset asserted during KEY_WAITED with digit_count 3 -> SHOW_TIME, count 0, no pulses.

Source files
------------

// File: rtl/alarm_clock_ctrl_fsm_if.sv
// alarm_clock_ctrl_fsm_if: keypad/button/second-tick inputs and control outputs of the alarm clock FSM
interface alarm_clock_ctrl_fsm_if #(
    parameter int NUM_DIGITS = 4
);
    logic [3:0]                      key;
    logic                            alarm_button;
    logic                            time_button;
    logic                            one_second;
    logic                            load_new_a;
    logic                            show_a;
    logic                            show_new_time;
    logic                            load_new_c;
    logic                            shift;
    logic [$clog2(NUM_DIGITS+1)-1:0] digit_count;
    logic                            entry_abort;

    modport master (
        output key, alarm_button, time_button, one_second,
        input  load_new_a, show_a, show_new_time, load_new_c, shift, digit_count, entry_abort
    );

    modport slave (
        input  key, alarm_button, time_button, one_second,
        output load_new_a, show_a, show_new_time, load_new_c, shift, digit_count, entry_abort
    );
endinterface

// File: rtl/alarm_clock_ctrl_fsm.sv
// alarm_clock_ctrl_fsm: sequences keypad entry, commits it to alarm/time and selects the display source
module alarm_clock_ctrl_fsm #(
    parameter int NUM_DIGITS   = 4,
    parameter int KEY_TIMEOUT  = 10,
    parameter int NOKEY        = 10,
    parameter bit REQUIRE_FULL = 1'b1
) (
    input logic                   clock,
    input logic                   reset,
    alarm_clock_ctrl_fsm_if.slave bus
);
    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int TW = $clog2(KEY_TIMEOUT + 1);
    localparam logic [CW-1:0] FULL = CW'(NUM_DIGITS);
    localparam logic [TW-1:0] TMAX = TW'(KEY_TIMEOUT);
    localparam logic [3:0] RELEASE_CODE = 4'(NOKEY);

    typedef enum logic [2:0] {
        SHOW_TIME,
        SHOW_ALARM,
        KEY_STORED,
        KEY_WAITED,
        KEY_ENTRY,
        SET_ALARM,
        SET_TIME
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] count, count_next;
    logic [TW-1:0] timer, timer_next, timer_inc;
    logic          abort, abort_next;
    logic          is_digit, is_release, full, commit_ok, timing, accept, timer_hit;

    assign is_digit   = bus.key <= 4'd9;
    assign is_release = bus.key == RELEASE_CODE;
    assign full       = count == FULL;
    assign commit_ok  = REQUIRE_FULL ? full : count != '0;
    assign timing     = state == KEY_WAITED || state == KEY_ENTRY;
    assign accept     = state == KEY_ENTRY && is_digit && !full;
    assign timer_inc  = timer == TMAX ? TMAX : timer + TW'(1);
    // an accepted digit beats a simultaneous timeout; the timer restarts in KEY_STORED
    assign timer_hit  = timing && bus.one_second && timer_inc == TMAX && !accept;

    // state, digit counter, inactivity timer and the registered abort pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= SHOW_TIME;
            count <= '0;
            timer <= '0;
            abort <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            timer <= timer_next;
            abort <= abort_next;
        end
    end

    // next-state logic; the timeout overrides every button decision in its cycle
    always_comb begin
        state_next = state;
        count_next = count;
        timer_next = timer;
        abort_next = 1'b0;
        case (state)
            SHOW_TIME:  state_next = is_digit ? KEY_STORED : bus.alarm_button ? SHOW_ALARM : SHOW_TIME;
            SHOW_ALARM: state_next = bus.alarm_button ? SHOW_ALARM : SHOW_TIME;
            KEY_STORED: begin
                state_next = KEY_WAITED;
                count_next = full ? count : count + CW'(1);
                timer_next = '0;
            end
            KEY_WAITED: begin
                timer_next = bus.one_second ? timer_inc : timer;
                state_next = is_release ? KEY_ENTRY : KEY_WAITED;
            end
            KEY_ENTRY: begin
                timer_next = bus.one_second ? timer_inc : timer;
                state_next = accept ? KEY_STORED :
                             bus.alarm_button && commit_ok ? SET_ALARM :
                             bus.time_button && commit_ok ? SET_TIME : KEY_ENTRY;
            end
            SET_ALARM, SET_TIME: begin
                state_next = SHOW_TIME;
                count_next = '0;
                timer_next = '0;
            end
            default: state_next = SHOW_TIME;
        endcase
        if (timer_hit) begin
            state_next = SHOW_TIME;
            count_next = '0;
            timer_next = '0;
            abort_next = 1'b1;
        end
    end

    assign bus.load_new_a    = state == SET_ALARM;
    assign bus.load_new_c    = state == SET_TIME;
    assign bus.shift         = state == KEY_STORED;
    assign bus.show_a        = state == SHOW_ALARM;
    assign bus.show_new_time = state == KEY_WAITED || state == KEY_ENTRY;
    assign bus.digit_count   = count;
    assign bus.entry_abort   = abort;
endmodule
